id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the RISC-V core. It sits directly downstream of the decode-stage control mux (the bubble-insertion stage) and captures that mux's gated control bundle, together with the decode-stage operands, for the execute stage. It supports stall (hold), flush (kill), and bubble tracking. A saturating counter records how many bubbles entered EX, for performance debug.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register-index width
- CNTW, 16, bubble-counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold all EX-side state this cycle
- flush  in  1  replace the captured entry with a bubble (taken branch or exception)
- idBubble  in  1  decode-stage select that zeroed the control bundle this cycle
- idAluOp  in  2  ALU operation class
- idBranch, idMemWrite, idRegWrite, idMemToReg, idAluSRC, idMemRead  in  1 each  decode-stage control bits
- idPc  in  XLEN  instruction PC
- idRs1Data, idRs2Data  in  XLEN  register-file read data
- idImm  in  XLEN  sign-extended immediate
- idRs1, idRs2, idRd  in  REGW  register indices
- idFunct3  in  3  funct3 field
- idFunct7b5  in  1  instruction bit 30
- exAluOp  out  2  registered control
- exBranch, exMemWrite, exRegWrite, exMemToReg, exAluSRC, exMemRead  out  1 each  registered control
- exPc, exRs1Data, exRs2Data, exImm  out  XLEN  registered data
- exRs1, exRs2, exRd  out  REGW  registered indices
- exFunct3  out  3  registered field
- exFunct7b5  out  1  registered field
- exValid  out  1  1 = real instruction in EX, 0 = bubble
- bubbleCnt  out  CNTW  number of bubbles loaded into EX, saturating

## Operation
- Update priority, evaluated each rising edge: reset > flush > stall > load.
- **reset:** every output is 0, including exValid and bubbleCnt.
- **flush:** all control outputs and all data/index outputs are set to 0, and exValid is set to 0. bubbleCnt increments. Flush overrides a simultaneous stall.
- **stall (no flush):** every output holds its value, and bubbleCnt holds.
- **load:** every ex* output takes its id* counterpart.
  - exValid is set to the inverse of idBubble.
  - If idBubble = 1, bubbleCnt increments. The control inputs are already zero, and the register captures them unchanged; it does not re-gate them.
  - Data fields are captured even on a bubble.
- **bubbleCnt saturation:** the counter saturates at 2^CNTW−1 and never wraps. An increment attempted at the maximum value leaves it unchanged.
- A store or register write is only architecturally meaningful when exValid = 1. Downstream stages qualify exMemWrite and exRegWrite with exValid; this block does not.

## Timing
- Latency is 1 cycle: id* values present at edge N appear on ex* after edge N.
- Outputs are purely registered, with no combinational path from input to output.
- Reset asserted mid-stall or mid-flush wins in that same cycle. On the first edge after reset deasserts, normal load resumes.
- Back-to-back flushes give one bubble and one count per cycle.
- If stall is asserted for K cycles, the entry is held for K cycles and the counter is unchanged.

## Structure
- The shared package `core_pkg` holds:
  - the `ctrl_t` packed struct {aluOp[1:0], branch, memWrite, regWrite, memToReg, aluSRC, memRead}
  - the `CTRL_NOP` constant (all zero)
  - the default XLEN and REGW.
  - Upstream and downstream blocks use the same `ctrl_t`.
- One sub-module, `sat_counter` (parameter CNTW; inputs clk, reset, inc, hold; output count), implements bubbleCnt.
- The register itself is a single always_ff with the priority chain above.

## Test plan
- **Reset:** drive all inputs to nonzero with reset = 1 for 2 cycles → all outputs are 0 and bubbleCnt = 0. Release reset with idRegWrite = 1, idRd = 5'd7, idBubble = 0 → next cycle exRegWrite = 1, exRd = 7, exValid = 1.
- **Load:** idPc = 32'h0000_0040, idImm = 32'hFFFF_FFFC, idAluOp = 2'b10 → after one edge exPc = 32'h40, exImm = 32'hFFFF_FFFC, exAluOp = 2'b10.
- **Stall:** load an entry with exRd = 3, then assert stall for 3 cycles while the id* inputs change → exRd stays 3 and bubbleCnt is unchanged. Drop stall → the new id* values appear after one edge.
- **Flush over stall:** assert flush and stall together while exMemWrite = 1 → next cycle all control outputs are 0, exValid = 0 and bubbleCnt = 1.
- **Load-use bubble:** idBubble = 1 with all control inputs 0 and idRs1Data = 32'h1234 → exValid = 0, exRs1Data = 32'h1234, bubbleCnt increments by 1.
- **Saturation:** with CNTW = 4, apply 20 consecutive flushes → bubbleCnt climbs to 15 and stays at 15. Then apply reset → bubbleCnt = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Types and defaults shared by the decode, ID/EX and execute stages.
package core_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REGW_DEF = 5;

   typedef struct packed {
      logic [1:0] aluOp;
      logic       branch;
      logic       memWrite;
      logic       regWrite;
      logic       memToReg;
      logic       aluSRC;
      logic       memRead;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with hold; hold wins over inc, reset wins over both.
module sat_counter #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   input  logic            hold,
   output logic [CNTW-1:0] count
);

   logic [CNTW-1:0] count_q;
   logic [CNTW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (!hold && inc && !(&count_q)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the gated control bundle and operands,
// with stall/flush handling and a saturating count of bubbles entering EX.
module id_ex_reg
   import core_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            idBubble,
   input  logic [1:0]      idAluOp,
   input  logic            idBranch,
   input  logic            idMemWrite,
   input  logic            idRegWrite,
   input  logic            idMemToReg,
   input  logic            idAluSRC,
   input  logic            idMemRead,
   input  logic [XLEN-1:0] idPc,
   input  logic [XLEN-1:0] idRs1Data,
   input  logic [XLEN-1:0] idRs2Data,
   input  logic [XLEN-1:0] idImm,
   input  logic [REGW-1:0] idRs1,
   input  logic [REGW-1:0] idRs2,
   input  logic [REGW-1:0] idRd,
   input  logic [2:0]      idFunct3,
   input  logic            idFunct7b5,
   output logic [1:0]      exAluOp,
   output logic            exBranch,
   output logic            exMemWrite,
   output logic            exRegWrite,
   output logic            exMemToReg,
   output logic            exAluSRC,
   output logic            exMemRead,
   output logic [XLEN-1:0] exPc,
   output logic [XLEN-1:0] exRs1Data,
   output logic [XLEN-1:0] exRs2Data,
   output logic [XLEN-1:0] exImm,
   output logic [REGW-1:0] exRs1,
   output logic [REGW-1:0] exRs2,
   output logic [REGW-1:0] exRd,
   output logic [2:0]      exFunct3,
   output logic            exFunct7b5,
   output logic            exValid,
   output logic [CNTW-1:0] bubbleCnt
);

   ctrl_t           id_ctrl;
   ctrl_t           ctrl_q;
   logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [REGW-1:0] rs1_q, rs2_q, rd_q;
   logic [2:0]      funct3_q;
   logic            funct7b5_q;
   logic            valid_q;
   logic            bubble_inc;
   logic            cnt_hold;

   // Control arrives already gated by the decode mux; no re-gating here.
   assign id_ctrl = '{aluOp:    idAluOp,
                      branch:   idBranch,
                      memWrite: idMemWrite,
                      regWrite: idRegWrite,
                      memToReg: idMemToReg,
                      aluSRC:   idAluSRC,
                      memRead:  idMemRead};

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ctrl_q     <= CTRL_NOP;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (!stall) begin
         ctrl_q     <= id_ctrl;
         pc_q       <= idPc;
         rs1_data_q <= idRs1Data;
         rs2_data_q <= idRs2Data;
         imm_q      <= idImm;
         rs1_q      <= idRs1;
         rs2_q      <= idRs2;
         rd_q       <= idRd;
         funct3_q   <= idFunct3;
         funct7b5_q <= idFunct7b5;
         valid_q    <= ~idBubble;
      end
   end

   // A flush always counts, even against a stall; a decode bubble counts only when loaded.
   assign bubble_inc = flush | (~stall & idBubble);
   assign cnt_hold   = stall & ~flush;

   sat_counter #(.CNTW(CNTW)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bubble_inc),
      .hold  (cnt_hold),
      .count (bubbleCnt)
   );

   assign exAluOp    = ctrl_q.aluOp;
   assign exBranch   = ctrl_q.branch;
   assign exMemWrite = ctrl_q.memWrite;
   assign exRegWrite = ctrl_q.regWrite;
   assign exMemToReg = ctrl_q.memToReg;
   assign exAluSRC   = ctrl_q.aluSRC;
   assign exMemRead  = ctrl_q.memRead;
   assign exPc       = pc_q;
   assign exRs1Data  = rs1_data_q;
   assign exRs2Data  = rs2_data_q;
   assign exImm      = imm_q;
   assign exRs1      = rs1_q;
   assign exRs2      = rs2_q;
   assign exRd       = rd_q;
   assign exFunct3   = funct3_q;
   assign exFunct7b5 = funct7b5_q;
   assign exValid    = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed plus randomized bench for id_ex_reg against a rule-level model of the EX-side entry.
module tb_id_ex_reg;

   localparam int XLEN = 32;
   localparam int REGW = 5;
   localparam int CNTW = 4;
   localparam int CMAX = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            reset, stall, flush, idBubble;
   logic [1:0]      idAluOp;
   logic            idBranch, idMemWrite, idRegWrite, idMemToReg, idAluSRC, idMemRead;
   logic [XLEN-1:0] idPc, idRs1Data, idRs2Data, idImm;
   logic [REGW-1:0] idRs1, idRs2, idRd;
   logic [2:0]      idFunct3;
   logic            idFunct7b5;
   logic [1:0]      exAluOp;
   logic            exBranch, exMemWrite, exRegWrite, exMemToReg, exAluSRC, exMemRead;
   logic [XLEN-1:0] exPc, exRs1Data, exRs2Data, exImm;
   logic [REGW-1:0] exRs1, exRs2, exRd;
   logic [2:0]      exFunct3;
   logic            exFunct7b5, exValid;
   logic [CNTW-1:0] bubbleCnt;

   int checks = 0;
   int failures = 0;

   // Reference model: the entry visible in EX as one flat record, plus the bubble tally.
   localparam int ENTW = 8 + 4*XLEN + 3*REGW + 4 + 1;
   logic [ENTW-1:0] m_entry;
   int              m_cnt;

   always #5 clk = ~clk;

   id_ex_reg #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .idBubble(idBubble),
      .idAluOp(idAluOp), .idBranch(idBranch), .idMemWrite(idMemWrite),
      .idRegWrite(idRegWrite), .idMemToReg(idMemToReg), .idAluSRC(idAluSRC),
      .idMemRead(idMemRead), .idPc(idPc), .idRs1Data(idRs1Data), .idRs2Data(idRs2Data),
      .idImm(idImm), .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idFunct3(idFunct3),
      .idFunct7b5(idFunct7b5),
      .exAluOp(exAluOp), .exBranch(exBranch), .exMemWrite(exMemWrite),
      .exRegWrite(exRegWrite), .exMemToReg(exMemToReg), .exAluSRC(exAluSRC),
      .exMemRead(exMemRead), .exPc(exPc), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
      .exImm(exImm), .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd), .exFunct3(exFunct3),
      .exFunct7b5(exFunct7b5), .exValid(exValid), .bubbleCnt(bubbleCnt)
   );

   function automatic logic [ENTW-1:0] id_entry();
      return {idAluOp, idBranch, idMemWrite, idRegWrite, idMemToReg, idAluSRC, idMemRead,
              idPc, idRs1Data, idRs2Data, idImm, idRs1, idRs2, idRd, idFunct3, idFunct7b5,
              ~idBubble};
   endfunction

   function automatic logic [ENTW-1:0] ex_entry();
      return {exAluOp, exBranch, exMemWrite, exRegWrite, exMemToReg, exAluSRC, exMemRead,
              exPc, exRs1Data, exRs2Data, exImm, exRs1, exRs2, exRd, exFunct3, exFunct7b5,
              exValid};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model by the edge rules, then compare on the falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (reset) begin
         m_entry = '0;
         m_cnt   = 0;
      end else if (flush) begin
         m_entry = '0;
         m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (!stall) begin
         m_entry = id_entry();
         if (idBubble) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
      @(negedge clk);
      check({tag, "_entry"}, 256'(ex_entry()), 256'(m_entry));
      check({tag, "_cnt"}, 256'(bubbleCnt), 256'(m_cnt));
   endtask

   task automatic rand_inputs(input logic bubble);
      idBubble   = bubble;
      idAluOp    = bubble ? 2'b00 : 2'($urandom_range(0, 3));
      idBranch   = bubble ? 1'b0 : 1'($urandom_range(0, 1));
      idMemWrite = bubble ? 1'b0 : 1'($urandom_range(0, 1));
      idRegWrite = bubble ? 1'b0 : 1'($urandom_range(0, 1));
      idMemToReg = bubble ? 1'b0 : 1'($urandom_range(0, 1));
      idAluSRC   = bubble ? 1'b0 : 1'($urandom_range(0, 1));
      idMemRead  = bubble ? 1'b0 : 1'($urandom_range(0, 1));
      idPc       = $urandom();
      idRs1Data  = $urandom();
      idRs2Data  = $urandom();
      idImm      = $urandom();
      idRs1      = 5'($urandom_range(0, 31));
      idRs2      = 5'($urandom_range(0, 31));
      idRd       = 5'($urandom_range(0, 31));
      idFunct3   = 3'($urandom_range(0, 7));
      idFunct7b5 = 1'($urandom_range(0, 1));
   endtask

   initial begin
      m_entry = '0;
      m_cnt   = 0;
      stall = 1'b1; flush = 1'b1; reset = 1'b1;
      rand_inputs(1'b0);
      idAluOp = 2'b11; idBranch = 1'b1; idMemWrite = 1'b1; idRegWrite = 1'b1;
      idMemToReg = 1'b1; idAluSRC = 1'b1; idMemRead = 1'b1; idBubble = 1'b1;
      idPc = 32'hDEAD_BEEF; idRd = 5'd31;
      @(negedge clk);
      step("reset1");
      step("reset2");
      check("reset_valid", 256'(exValid), 256'(0));

      // Release reset with a register-writing instruction.
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      rand_inputs(1'b0);
      idRegWrite = 1'b1; idRd = 5'd7;
      step("rel");
      check("rel_rd", 256'(exRd), 256'(7));
      check("rel_valid", 256'(exValid), 256'(1));

      rand_inputs(1'b0);
      idPc = 32'h0000_0040; idImm = 32'hFFFF_FFFC; idAluOp = 2'b10;
      step("load");
      check("load_pc", 256'(exPc), 256'(32'h40));
      check("load_imm", 256'(exImm), 256'(32'hFFFF_FFFC));

      rand_inputs(1'b0);
      idRd = 5'd3; idMemWrite = 1'b1;
      step("stall_ld");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs(($urandom_range(0, 1)) == 1);
         step("stall");
         check("stall_rd", 256'(exRd), 256'(3));
      end
      stall = 1'b0;
      rand_inputs(1'b0);
      idMemWrite = 1'b1;
      step("unstall");

      // Flush wins over stall while a store sits in EX.
      stall = 1'b1; flush = 1'b1;
      rand_inputs(1'b0);
      step("flush_stall");
      check("fs_memwr", 256'(exMemWrite), 256'(0));
      check("fs_cnt", 256'(bubbleCnt), 256'(1));
      stall = 1'b0; flush = 1'b0;

      rand_inputs(1'b1);
      idRs1Data = 32'h1234;
      step("bubble");
      check("bub_rs1", 256'(exRs1Data), 256'(32'h1234));
      check("bub_cnt", 256'(bubbleCnt), 256'(2));

      flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_inputs(1'b0);
         step("sat");
      end
      check("sat_cnt", 256'(bubbleCnt), 256'(CMAX));
      flush = 1'b0; reset = 1'b1;
      step("sat_rst");
      check("sat_rst_cnt", 256'(bubbleCnt), 256'(0));
      reset = 1'b0;

      for (int i = 0; i < 300; i++) begin
         reset = ($urandom_range(0, 29) == 0);
         flush = ($urandom_range(0, 5) == 0);
         stall = ($urandom_range(0, 3) == 0);
         rand_inputs($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
